// File: rtl/reg_write_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_write_tx_pkg: shared constants for the register-write transmitter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package reg_write_tx_pkg;

  localparam int c_ADDR_BITS = 3;

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_LO_SETUP = 3'd1;
  localparam logic [2:0] c_ST_LO_HOLD  = 3'd2;
  localparam logic [2:0] c_ST_HI_SETUP = 3'd3;
  localparam logic [2:0] c_ST_HI_HOLD  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/reg_write_tx_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync2: two-flop synchroniser with configurable reset value            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/reg_write_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_write_tx: host-side two-phase register-write protocol transmitter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module reg_write_tx
  import reg_write_tx_pkg::*;
#(
  parameter int ADDR_BITS      = c_ADDR_BITS,
  parameter int HOLD_CYCLES    = 4,
  parameter int ECHO_EN        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [15:0]          req_data,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  input  logic                 clear_err,
  output logic [7:0]           data_out,
  output logic [ADDR_BITS-1:0] addr_out,
  output logic                 data_part_out,
  output logic                 echo_out,
  input  logic                 echo_in
);

  localparam int                c_HCW       = $clog2(HOLD_CYCLES) + 1;
  localparam logic [c_HCW-1:0]  c_HOLD_LAST = c_HCW'(HOLD_CYCLES - 1);
  localparam logic [7:0]        c_TIMEOUT   = 8'(TIMEOUT_CYCLES);

  logic [2:0]           r_state;
  logic [15:0]          r_data;
  logic [c_HCW-1:0]     r_hold_cnt;
  logic [7:0]           r_to_cnt;
  logic [7:0]           r_data_out;
  logic [ADDR_BITS-1:0] r_addr_out;
  logic                 r_data_part;
  logic                 r_echo;
  logic                 r_done;
  logic                 r_err;

  logic w_echo_sync;
  logic w_hold_ok;
  logic w_echo_ok;
  logic w_tmo;
  logic w_exit;

  sync2 #(.RESET_VAL(1'b0)) u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo_in),
    .q     (w_echo_sync)
  );

  // A phase ends once the hold is met and the echo has returned, or the echo wait timed out.
  assign w_hold_ok = (r_hold_cnt >= c_HOLD_LAST);
  assign w_echo_ok = (ECHO_EN == 0) || (w_echo_sync == r_echo);
  assign w_tmo     = (r_to_cnt >= c_TIMEOUT);
  assign w_exit    = w_hold_ok && (w_echo_ok || w_tmo);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_data      <= 16'h0000;
      r_hold_cnt  <= '0;
      r_to_cnt    <= 8'h00;
      r_data_out  <= 8'h00;
      r_addr_out  <= '0;
      r_data_part <= 1'b1;
      r_echo      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear_err) r_err <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (req_valid) begin
            r_data     <= req_data;
            r_data_out <= req_data[7:0];
            r_addr_out <= req_addr;
            r_state    <= c_ST_LO_SETUP;
          end
        end
        c_ST_LO_SETUP, c_ST_HI_SETUP: begin
          r_data_part <= (r_state == c_ST_HI_SETUP);
          if (ECHO_EN != 0) r_echo <= ~r_echo;
          r_hold_cnt  <= '0;
          r_to_cnt    <= 8'h00;
          r_state     <= (r_state == c_ST_LO_SETUP) ? c_ST_LO_HOLD : c_ST_HI_HOLD;
        end
        c_ST_LO_HOLD, c_ST_HI_HOLD: begin
          if (!w_hold_ok) r_hold_cnt <= r_hold_cnt + 1'b1;
          else if (!w_echo_ok && !w_tmo) r_to_cnt <= r_to_cnt + 1'b1;
          if (w_exit) begin
            // Setting err after the clear above gives set priority.
            if (!w_echo_ok) r_err <= 1'b1;
            if (r_state == c_ST_LO_HOLD) begin
              r_data_out <= r_data[15:8];
              r_state    <= c_ST_HI_SETUP;
            end else begin
              r_done  <= 1'b1;
              r_state <= c_ST_IDLE;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == c_ST_IDLE);
  assign busy          = (r_state != c_ST_IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign data_out      = r_data_out;
  assign addr_out      = r_addr_out;
  assign data_part_out = r_data_part;
  assign echo_out      = r_echo;

endmodule
`default_nettype wire
